// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state type, default window/timeout values and target
// indices for the data-memory request router and its address decoder.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FWD,
      WAIT,
      RESP
   } state_t;

   localparam logic [31:0] DEF_MMIO_BASE = 32'h8000_0000;
   localparam logic [31:0] DEF_MMIO_SIZE = 32'h0001_0000;
   localparam int unsigned DEF_TIMEOUT   = 16;

   localparam logic TGT_RAM  = 1'b0;
   localparam logic TGT_MMIO = 1'b1;

   // True when addr falls in the power-of-two window starting at base.
   function automatic logic in_window(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] size);
      return (addr & ~(size - 32'd1)) == base;
   endfunction

endpackage

// File: rtl/dmem_addr_decode.sv
// dmem_addr_decode: combinational MMIO window compare; sel = 1 selects the
// MMIO target, sel = 0 the data RAM.
module dmem_addr_decode
   import dmem_pkg::*;
#(
   parameter logic [31:0] MMIO_BASE = DEF_MMIO_BASE,
   parameter logic [31:0] MMIO_SIZE = DEF_MMIO_SIZE
) (
   input  logic [31:0] addr,
   output logic        sel
);

   // Mask off the in-window offset bits and match against the base.
   always_comb begin
      sel = in_window(addr, MMIO_BASE, MMIO_SIZE) ? TGT_MMIO : TGT_RAM;
   end

endmodule

// File: rtl/dmem_demux_router.sv
// dmem_demux_router: steers one core data-memory request at a time to either
// the data RAM (port 0) or the MMIO peripherals (port 1), returns the read
// response, and reports a bus error if the target does not answer in time.
module dmem_demux_router
   import dmem_pkg::*;
#(
   parameter logic [31:0] MMIO_BASE = DEF_MMIO_BASE,
   parameter logic [31:0] MMIO_SIZE = DEF_MMIO_SIZE,
   parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
   input  logic        clk,
   input  logic        rst_n,

   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_we,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,

   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,

   output logic        t0_valid,
   output logic        t1_valid,
   input  logic        t0_ready,
   input  logic        t1_ready,
   output logic [31:0] t_addr,
   output logic        t_we,
   output logic [31:0] t_wdata,
   output logic [3:0]  t_be,
   input  logic        t0_rsp_valid,
   input  logic        t1_rsp_valid,
   input  logic [31:0] t0_rsp_rdata,
   input  logic [31:0] t1_rsp_rdata
);

   localparam int unsigned   CW       = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_MAX  = '1;

   state_t        state_q;
   state_t        state_d;
   logic          sel_q;
   logic [CW-1:0] cnt_q;
   logic [31:0]   rdata_q;
   logic          err_q;

   logic          addr_sel;
   logic          tgt_ready;
   logic          tgt_rsp_valid;
   logic [31:0]   tgt_rsp_rdata;
   logic          timeout_hit;

   dmem_addr_decode #(
      .MMIO_BASE (MMIO_BASE),
      .MMIO_SIZE (MMIO_SIZE)
   ) u_decode (
      .addr (req_addr),
      .sel  (addr_sel)
   );

   // Pick the handshake and response signals of the latched target only.
   always_comb begin
      tgt_ready     = 1'b0;
      tgt_rsp_valid = 1'b0;
      tgt_rsp_rdata = '0;
      if (sel_q == TGT_MMIO) begin
         tgt_ready     = t1_ready;
         tgt_rsp_valid = t1_rsp_valid;
         tgt_rsp_rdata = t1_rsp_rdata;
      end else begin
         tgt_ready     = t0_ready;
         tgt_rsp_valid = t0_rsp_valid;
         tgt_rsp_rdata = t0_rsp_rdata;
      end
      timeout_hit = (cnt_q == CNT_LAST);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and handshake/response outputs.
   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      t0_valid  = 1'b0;
      t1_valid  = 1'b0;
      rsp_valid = 1'b0;
      rsp_rdata = '0;
      rsp_err   = 1'b0;
      case (state_q)
         IDLE: begin
            // Gated by rst_n so every output reads 0 while reset is held.
            req_ready = rst_n;
            if (req_valid) begin
               state_d = FWD;
            end
         end
         FWD: begin
            t0_valid = (sel_q == TGT_RAM);
            t1_valid = (sel_q == TGT_MMIO);
            if (tgt_ready) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (tgt_rsp_valid || timeout_hit) begin
               state_d = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            rsp_rdata = rdata_q;
            rsp_err   = err_q;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Request latch, wait counter and response capture.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         t_addr  <= '0;
         t_we    <= 1'b0;
         t_wdata <= '0;
         t_be    <= '0;
         sel_q   <= TGT_RAM;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  t_addr  <= req_addr;
                  t_we    <= req_we;
                  t_wdata <= req_wdata;
                  t_be    <= req_be;
                  sel_q   <= addr_sel;
               end
            end
            FWD: begin
               if (tgt_ready) begin
                  cnt_q <= '0;
               end
            end
            WAIT: begin
               if (cnt_q != CNT_MAX) begin
                  cnt_q <= cnt_q + 1'b1;
               end
               // A response in the timeout cycle still wins.
               if (tgt_rsp_valid) begin
                  rdata_q <= t_we ? '0 : tgt_rsp_rdata;
                  err_q   <= 1'b0;
               end else if (timeout_hit) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/dmem_demux_router.md
Name: dmem_demux_router

Overview:
- 1-to-2 request router on the core's data-memory path, between the load/store stage and two targets: port 0 (data RAM) and port 1 (MMIO peripherals).
- Decodes each request address and steers the request to exactly one target using a valid/ready handshake.
- Returns that target's read response to the core.
- Allows one transaction in flight at a time, with a response timeout that produces a bus error.

Parameters:
- MMIO_BASE, 32'h8000_0000, first byte address routed to port 1.
- MMIO_SIZE, 32'h0001_0000, byte size of the MMIO window. Must be a power of two; MMIO_BASE is aligned to it.
- TIMEOUT, 16, cycles to wait for a target response before signalling an error. Must be at least 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  router accepts the request.
- req_addr  in  32  byte address.
- req_we  in  1  1 = store, 0 = load.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables.
- rsp_valid  out  1  one-cycle response pulse to the core.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  error flag, qualified by rsp_valid.
- t0_valid, t1_valid  out  1  per-target request valid.
- t0_ready, t1_ready  in  1  per-target accept.
- t_addr  out  32  latched address, shared by both targets.
- t_we  out  1  latched write enable, shared.
- t_wdata  out  32  latched store data, shared.
- t_be  out  4  latched byte enables, shared.
- t0_rsp_valid, t1_rsp_valid  in  1  per-target response valid.
- t0_rsp_rdata, t1_rsp_rdata  in  32  per-target response data.

Behaviour:
- Reset (rst_n low at a clock edge):
  - State goes to IDLE; timeout counter is cleared; latched fields are cleared.
  - All outputs are 0: req_ready, rsp_valid, rsp_err, rsp_rdata, t0_valid, t1_valid, t_addr, t_we, t_wdata, t_be.
- Reset mid-transaction: abandons the transaction with no response to the core. Any late target response arriving after reset is ignored.
- State IDLE:
  - req_ready = 1.
  - On req_valid: latch addr/we/wdata/be and sel = (req_addr inside MMIO window); go to FWD.
- State FWD:
  - Assert t<sel>_valid with the latched fields. The other target's valid stays 0.
  - On t<sel>_ready, go to WAIT next cycle and clear the counter.
  - Valid and fields are held stable until ready (no withdrawal).
  - There is no timeout in FWD.
- State WAIT:
  - Counter increments each cycle.
  - On t<sel>_rsp_valid: go to RESP and capture rdata (stores capture 0).
  - Responses on the non-selected target are ignored.
  - If the counter reaches TIMEOUT - 1 without a response: go to RESP with err = 1 and rdata = 0.
  - A response arriving in that same cycle wins over the timeout (no error).
- State RESP:
  - Registered outputs are driven for exactly one cycle: rsp_valid = 1 with rsp_rdata and rsp_err.
  - Then go to IDLE.
- req_ready is 0 in FWD, WAIT and RESP.
- Minimum latency, request accept to rsp_valid, is 3 cycles (ready and rsp_valid both on the first possible cycle).
- Throughput is at most one transaction per 4 cycles.
- Misaligned requests are forwarded unchanged; alignment checking is the core's job.
- Address window test:
  - In window when (req_addr & ~(MMIO_SIZE-1)) == MMIO_BASE.
  - Boundaries: MMIO_BASE+MMIO_SIZE-1 goes to port 1; MMIO_BASE+MMIO_SIZE goes to port 0; MMIO_BASE-1 goes to port 0.
- Counter width is $clog2(TIMEOUT)+1 bits; the counter saturates and never wraps.

Decomposition:
- Shared package (dmem_pkg):
  - State enum {IDLE, FWD, WAIT, RESP}.
  - Default MMIO_BASE, MMIO_SIZE, TIMEOUT.
  - Target index constants TGT_RAM = 0, TGT_MMIO = 1.
- Sub-module dmem_addr_decode:
  - Combinational window compare; parameters MMIO_BASE and MMIO_SIZE; input addr; output sel.
  - Reused later by the instruction-fetch path.

Test Plan:
- Load from 32'h0000_0010: t0_ready on the first FWD cycle, t0_rsp_valid one cycle later with 32'hDEADBEEF -> t0_valid pulses; rsp_valid at cycle 3 after accept with rdata DEADBEEF, err = 0; t1_valid never asserted.
- Store to 32'h8000_0004 with wdata 32'h1234_5678, be 4'b0011: t1_ready delayed 3 cycles -> t1_valid and t_wdata/t_be held stable for all 4 FWD cycles; rsp_valid with rdata 0, err 0.
- Addresses 32'h8000_FFFC and 32'h8001_0000 -> routed to t1 and t0 respectively.
- Load to MMIO, target never responds, TIMEOUT = 16 -> rsp_valid with err = 1 and rdata 0, exactly 16 WAIT cycles after accept.
- rst_n asserted low during WAIT, and t0_rsp_valid fired two cycles after release -> no rsp_valid; req_ready = 1 on the first cycle after release.
- Spurious t1_rsp_valid while waiting on t0 -> ignored; the correct t0 data is returned.
